assign_checker: RTL and testbench

ASSIGN_CHECKER -- requirements
Module: assign_checker

---
 rtl/assign_checker.sv | 112 +++++++++++
 tb/tb_assign_checker.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/assign_checker.sv
// rtl/assign_checker.sv - Checks c1/c2/c3 from an observed block against a&b over a fixed-length run.
module assign_checker #(
    parameter int N_CHECK = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       a,
    input  logic       b,
    input  logic       c1,
    input  logic       c2,
    input  logic       c3,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] err_cnt,
    output logic [2:0] first_err
);

    typedef enum logic [1:0] {IDLE, ARM, CHECK, DONE} state_t;

    localparam logic [7:0] LAST_CNT = 8'(N_CHECK - 1);

    state_t     r_state;
    logic       r_exp;
    logic [7:0] r_cnt;
    logic       r_busy;
    logic       r_done;
    logic       r_err;
    logic [7:0] r_err_cnt;
    logic [2:0] r_first_err;

    logic       w_ab;
    logic [2:0] w_m;

    assign w_ab = a & b;
    // c3 is edge-triggered, so it is compared against a&b captured on the previous edge
    assign w_m  = {c3 != r_exp, c2 != w_ab, c1 != w_ab};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_exp       <= 1'b0;
            r_cnt       <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= 8'd0;
            r_first_err <= 3'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_state     <= ARM;
                        r_busy      <= 1'b1;
                        r_err       <= 1'b0;
                        r_err_cnt   <= 8'd0;
                        r_first_err <= 3'd0;
                    end
                end
                ARM: begin
                    r_exp <= w_ab;
                    r_cnt <= 8'd0;
                    if (!en) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    // The compare in this cycle is kept even when the run is aborted
                    r_exp <= w_ab;
                    if (|w_m) begin
                        if (r_err_cnt != 8'hFF) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                        if (!r_err) begin
                            r_first_err <= w_m;
                            r_err       <= 1'b1;
                        end
                    end
                    if (!en) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == LAST_CNT) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;
    assign first_err = r_first_err;

endmodule

// File: tb/tb_assign_checker.sv
// tb/tb_assign_checker.sv - Randomized bench for assign_checker with a run-level reference model.
module tb_assign_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, en2;
    logic       a, b, cr;
    logic       c1, c2, c3;
    logic       tb_prev = 1'b0;
    int         mode;
    logic       busy, done, err;
    logic [7:0] err_cnt;
    logic [2:0] first_err;
    logic       busy2, done2, err2;
    logic [7:0] err_cnt2;
    logic [2:0] first_err2;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    // Stand-in for the observed block; mode selects which output is faulty
    always @(posedge clk) tb_prev <= a & b;
    always_comb begin
        c1 = a & b;
        c2 = a & b;
        c3 = tb_prev;
        if (mode == 1) c3 = 1'b0;
        if (mode == 2) c2 = tb_prev;
        if (mode == 3) c1 = ~(a & b);
        if (mode == 4) c1 = cr;
    end

    assign_checker #(.N_CHECK(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c1(c1), .c2(c2), .c3(c3),
        .busy(busy), .done(done), .err(err), .err_cnt(err_cnt), .first_err(first_err)
    );

    assign_checker #(.N_CHECK(255)) u_dut255 (
        .clk(clk), .rst_n(rst_n), .en(en2), .a(a), .b(b), .c1(c1), .c2(c2), .c3(c3),
        .busy(busy2), .done(done2), .err(err2), .err_cnt(err_cnt2), .first_err(first_err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One run on the N_CHECK=4 instance; abort_edge < 0 means en stays high.
    // Edge 0 is IDLE->ARM, edge 1 ARM->CHECK, edges 2..5 carry the compares.
    task automatic run4(input int md, input int abort_edge);
        int         cnt;
        logic [2:0] first;
        logic       prev;
        logic [2:0] m;
        bit         stop;
        cnt = 0; first = 3'd0; prev = 1'b0; stop = 1'b0; mode = md;
        for (int e = 0; e < 6 && !stop; e++) begin
            en = (abort_edge < 0 || e < abort_edge);
            if (md == 1) begin a = 1'b1; b = 1'b1; end
            else if (md == 2) begin a = ~a; b = 1'b1; end
            else begin a = 1'($urandom); b = 1'($urandom); end
            cr = 1'($urandom);
            #1;
            m = {c3 != prev, c2 != (a & b), c1 != (a & b)};
            if (e >= 2 && m != 3'd0) begin
                if (cnt == 0) first = m;
                if (cnt < 255) cnt++;
            end
            prev = a & b;
            @(posedge clk);
            @(negedge clk);
            stop = (abort_edge >= 0 && e >= abort_edge);
            chk("busy", busy, !stop && e < 5);
            chk("done", done, !stop && e == 5);
        end
        en = 1'b0;
        chk("err_cnt", err_cnt, cnt);
        chk("err", err, cnt != 0);
        chk("first_err", first_err, first);
        @(negedge clk);
        chk("done_after", done, 1'b0);
        chk("err_cnt_hold", err_cnt, cnt);
    endtask

    initial begin
        int ndone;
        int d1;
        int d2;
        rst_n = 1'b0; en = 1'b0; en2 = 1'b0; a = 1'b0; b = 1'b0; cr = 1'b0; mode = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_err_cnt", err_cnt, 8'd0);
        chk("rst_first_err", first_err, 3'd0);
        chk("rst_busy255", busy2, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        repeat (3) run4(0, -1);
        run4(1, -1);
        chk("c3_stuck_cnt", err_cnt, 8'd4);
        chk("c3_stuck_code", first_err, 3'b100);
        run4(2, -1);
        chk("c2_stale_cnt", err_cnt, 8'd4);
        chk("c2_stale_code", first_err, 3'b010);
        repeat (4) run4(4, -1);
        run4(3, 4);
        chk("abort_cnt", err_cnt, 8'd3);
        run4(0, 1);
        run4(0, -1);

        // Asynchronous reset in the middle of CHECK
        mode = 3; a = 1'b1; b = 1'b1; en = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("pre_rst_cnt", err_cnt, 8'd2);
        chk("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_err", err, 1'b0);
        chk("arst_err_cnt", err_cnt, 8'd0);
        chk("arst_first_err", first_err, 3'd0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_done", done, 1'b0);

        // Two back-to-back runs at N_CHECK=255 with c1 wrong every cycle
        mode = 3; ndone = 0; d1 = -1; d2 = -1; en2 = 1'b1;
        for (int e = 0; e < 600 && ndone < 2; e++) begin
            a = 1'($urandom); b = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (e == 257) chk("sat_hold_idle", err_cnt2, 8'd255);
            if (e == 258) begin
                chk("sat_clear_cnt", err_cnt2, 8'd0);
                chk("sat_clear_err", err2, 1'b0);
                chk("sat_arm_busy", busy2, 1'b1);
            end
            if (done2) begin
                if (ndone == 0) d1 = e; else d2 = e;
                chk("sat_cnt", err_cnt2, 8'd255);
                chk("sat_code", first_err2, 3'b001);
                ndone++;
                if (ndone == 2) en2 = 1'b0;
            end
        end
        chk("sat_done1_edge", d1, 256);
        chk("sat_done2_edge", d2, 514);
        repeat (2) @(negedge clk);
        chk("sat_idle_busy", busy2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
